// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for an in-place 256-point NTT (Cooley-Tukey) or
// inverse NTT (Gentleman-Sande) on the shared butterfly datapath.
// Issues one butterfly per cycle, drains the read/butterfly pipeline
// between layers and replays the read addresses as write-back addresses.
module ntt_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       sel_red_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_addr_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o,
  output logic       sel_red_o,
  output logic       sel_butterfly_o
);

  // Total read-to-write latency; also the length of the inter-layer drain.
  localparam int L     = MEM_LAT + BF_LAT;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(L - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_mode;      // 0 = forward CT, 1 = inverse GS
  logic             r_sel_red;   // 1 = Kyber, 0 = Dilithium
  logic [6:0]       r_j;         // butterfly index inside the layer
  logic [2:0]       r_lg;        // log2 of the current butterfly span
  logic [2:0]       r_layer;     // layers completed so far
  logic [CNT_W-1:0] r_drain;

  logic             w_run;
  logic             w_last_layer;
  logic [2:0]       w_lg_next;
  logic [7:0]       w_len;
  logic [7:0]       w_mask;
  logic [7:0]       w_j;
  logic [7:0]       w_g;
  logic [7:0]       w_addr_a;
  logic [7:0]       w_addr_b;
  logic [7:0]       w_tw_fwd;
  logic [7:0]       w_tw_inv;

  // Write-back delay line: {valid, addr_a, addr_b}, L stages deep.
  logic [16:0]      r_wb_pipe [L];

  assign w_run        = (r_state == S_RUN);
  // Kyber stops one layer early (span 2), Dilithium goes down to span 1.
  assign w_last_layer = (r_layer == (r_sel_red ? 3'd6 : 3'd7));
  // Forward halves the span each layer, inverse doubles it.
  assign w_lg_next    = r_mode ? (r_lg + 3'd1) : (r_lg - 3'd1);

  // Address generation: g = j / len, k = j mod len.
  // a = 2*len*g + k is j with the bits above k shifted up by one place,
  // which equals j + (j & ~(len-1)).
  assign w_len    = 8'd1 << r_lg;
  assign w_mask   = w_len - 8'd1;
  assign w_j      = {1'b0, r_j};
  assign w_g      = w_j >> r_lg;
  assign w_addr_a = w_j + (w_j & ~w_mask);
  assign w_addr_b = w_addr_a + w_len;

  // Forward twiddle 128/len + g. Inverse twiddle 256/len - 1 - g, where
  // 256/len - 1 is written as 255 >> lg to stay within 8 bits.
  assign w_tw_fwd = (8'd128 >> r_lg) + w_g;
  assign w_tw_inv = (8'd255 >> r_lg) - w_g;

  assign busy_o          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o          = (r_state == S_DONE);
  assign rd_en_o         = w_run;
  assign rd_addr_a_o     = w_run ? w_addr_a : 8'd0;
  assign rd_addr_b_o     = w_run ? w_addr_b : 8'd0;
  assign tw_addr_o       = w_run ? (r_mode ? w_tw_inv : w_tw_fwd) : 8'd0;
  assign sel_red_o       = r_sel_red;
  assign sel_butterfly_o = r_mode;

  assign wr_en_o     = r_wb_pipe[L-1][16];
  assign wr_addr_a_o = r_wb_pipe[L-1][15:8];
  assign wr_addr_b_o = r_wb_pipe[L-1][7:0];

  // Layer sequencing: IDLE -> RUN (128 issues) -> DRAIN (L cycles) -> RUN | DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_sel_red <= 1'b0;
      r_j       <= 7'd0;
      r_lg      <= 3'd0;
      r_layer   <= 3'd0;
      r_drain   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode    <= mode_i;
            r_sel_red <= sel_red_i;
            // Forward starts at span 128; inverse at 2 (Kyber) or 1 (Dilithium).
            r_lg      <= mode_i ? {2'b00, sel_red_i} : 3'd7;
            r_layer   <= 3'd0;
            r_j       <= 7'd0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          // r_j wraps to 0 after 127, ready for the next layer.
          r_j <= r_j + 7'd1;
          if (r_j == 7'd127) begin
            r_drain <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            if (w_last_layer) begin
              r_state <= S_DONE;
            end else begin
              r_layer <= r_layer + 3'd1;
              r_lg    <= w_lg_next;
              r_state <= S_RUN;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Delay the issued address pair by L cycles to form the write-back stream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < L; i++) begin
        r_wb_pipe[i] <= '0;
      end
    end else begin
      r_wb_pipe[0] <= {w_run, rd_addr_a_o, rd_addr_b_o};
      for (int i = 1; i < L; i++) begin
        r_wb_pipe[i] <= r_wb_pipe[i-1];
      end
    end
  end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer that drives the shared `butterfly` datapath through a complete in-place forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over a 256-coefficient polynomial, for either Kyber or Dilithium. It generates coefficient-memory read and write addresses, twiddle-ROM addresses and the `butterfly` configuration selects. It issues one butterfly per cycle and inserts pipeline drains between layers. It sits between the top-level command interface and the butterfly/coefficient RAM/twiddle ROM cluster.

## Interface
- `MEM_LAT`, 1: coefficient RAM read latency, in cycles; must be ≥1.
- `BF_LAT`, 1: butterfly register latency, in cycles; must be ≥0.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request; sampled only in IDLE.
- `mode_i` in 1: 0 = forward NTT (CT), 1 = inverse NTT (GS); latched at start.
- `sel_red_i` in 1: 1 = Kyber, 0 = Dilithium; latched at start.
- `busy_o` out 1: high while in RUN or DRAIN.
- `done_o` out 1: one-cycle pulse when the transform completes.
- `rd_en_o` out 1: read strobe, both RAM read ports.
- `rd_addr_a_o`, `rd_addr_b_o` out 8: read addresses for the butterfly a/b operands.
- `tw_addr_o` out 8: twiddle ROM address, issued in the same cycle as the read.
- `wr_en_o` out 1: write strobe, both RAM write ports.
- `wr_addr_a_o`, `wr_addr_b_o` out 8: write-back addresses for `a_out`/`b_out`.
- `sel_red_o` out 1: to `butterfly.sel_red_i`; equals the latched `sel_red`.
- `sel_butterfly_o` out 1: to `butterfly.sel_butterfly_i`; equals the latched `mode`.

## Operation
- **State machine: IDLE → RUN → DRAIN → (RUN | DONE) → IDLE.**
  - IDLE: when `start_i`=1, latch `mode`/`sel_red`, initialise the layer and go to RUN.
  - RUN: issue butterflies j = 0..127, one per cycle. After j = 127, go to DRAIN.
  - DRAIN: last exactly L = MEM_LAT+BF_LAT cycles. Then go to RUN for the next layer, or to DONE after the last layer.
  - DONE: one cycle with `done_o`=1, then return to IDLE.
- **Layer count:** Kyber = 7, Dilithium = 8.
- **Butterfly span `len`:**
  - Forward: starts at 128 and halves each layer (Kyber ends at 2, Dilithium at 1).
  - Inverse: starts at 2 (Kyber) or 1 (Dilithium) and doubles each layer up to 128.
- **Per issue j:**
  - g = j / len, k = j mod len.
  - `rd_addr_a_o` = 2·len·g + k; `rd_addr_b_o` = `rd_addr_a_o` + len.
- **Twiddle index:**
  - Forward: `tw_addr_o` = 128/len + g.
  - Inverse: `tw_addr_o` = 256/len − 1 − g.
  - All divisions are shifts, since len is a power of two.
  - ROM contents, including the negated inverse twiddles, are owned by the ROM, not by this block.
- **Write-back:** the write addresses equal the read addresses delayed by L cycles through a shift register. `wr_en_o` is `rd_en_o` delayed by L cycles.
- **Hazards:** the drain guarantees every write of layer n completes before the first read of layer n+1. No forwarding logic is needed.
- **Out of scope:** final n⁻¹ scaling after the inverse transform.
- **`start_i` while busy:** ignored. `mode_i`/`sel_red_i` changes while busy have no effect.
- **Reset:** asserting `rst_ni` at any time, including mid-transform, forces IDLE and all outputs to 0 with no further writes. RAM contents are then undefined.

## Timing
- Reset value of every output is 0.
- `start_i` high in IDLE at cycle 0 starts the first RUN cycle at cycle 1.
  - `busy_o`=1 and `rd_en_o`=1 from cycle 1 onward.
- A layer occupies 128+L cycles.
- `done_o` is high at cycle layers·(128+L)+1, with `busy_o`=0 in that same cycle.
- Back-to-back transforms: `start_i` is accepted in the cycle after DONE.
- Read data and the twiddle arrive MEM_LAT cycles after issue. The butterfly result arrives BF_LAT cycles later, coinciding with `wr_en_o`.
- `sel_red_o`/`sel_butterfly_o` are constant from cycle 1 until IDLE.

## Test plan
- **Kyber forward, L=2** (`mode_i`=0, `sel_red_i`=1) → expect:
  - cycle 1: rd 0/128, tw 1;
  - layer 2 first issue: rd 0/64, tw 2;
  - layer 2, j=64: rd 128/192, tw 3;
  - `done_o` pulse at cycle 911, 896 total writes.
- **Dilithium inverse, L=2** (`mode_i`=1, `sel_red_i`=0) → expect:
  - j=0: rd 0/1, tw 255;
  - j=1: rd 2/3, tw 254;
  - last layer: rd 0/128, tw 1;
  - `done_o` at cycle 1041.
- **Write alignment:** every `wr_en_o` pulse repeats the address pair issued exactly L cycles earlier. `wr_en_o` stays low for the first L cycles of each RUN.
- **Reset:** drop `rst_ni` at cycle 300 of a Kyber NTT → all outputs 0 immediately. A new `start_i` after release runs a full transform.
- **Start while busy:** `start_i` pulsed while busy, and `mode_i` toggled mid-run → no restart, selects unchanged, single `done_o`.
- **End-to-end:** behavioural RAM, ROM and butterfly models, with random Kyber and Dilithium polynomials → memory after forward then inverse (scaled by n⁻¹ in the bench) equals the input. Forward output matches the software NTT.
